// File: rtl/mips_pkg.sv
// Shared fetch-unit types and constants.
// Holds the fetch FSM state, reset PC default and MIPS jump/branch opcodes.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch unit and memory.
// One-cycle imem_valid pulse returns the word for the held address.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch unit.
// Priority: register jump, then J/JAL, then taken branch, then pc+4.
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] imm26_i,
    input  logic        jr_en_i,
    input  logic [31:0] jr_addr_i,
    input  logic        jump_i,
    input  logic        branch_i,
    input  logic        taken_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] jmp_pc;
    logic [31:0] br_off;
    logic [31:0] br_pc;

    assign seq_pc = pc_i + 32'd4;
    assign jmp_pc = {seq_pc[31:28], imm26_i, 2'b00};
    assign br_off = {{14{imm26_i[15]}}, imm26_i[15:0], 2'b00};
    assign br_pc  = seq_pc + br_off;

    // pick the highest-priority redirect target
    always_comb begin
        next_pc_o = seq_pc;
        priority case (1'b1)
            jr_en_i:             next_pc_o = word_align(jr_addr_i);
            jump_i:              next_pc_o = jmp_pc;
            branch_i && taken_i: next_pc_o = br_pc;
            default:             next_pc_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests words, holds them for decode,
// and redirects the fetch address when the decoder consumes one.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst_b,
    fetch_unit_if.master imem,
    output logic         inst_valid,
    output logic [31:0]  inst_out,
    output logic [31:0]  pc_out,
    input  logic         stall,
    input  logic         jump,
    input  logic         branch,
    input  logic         branch_taken,
    input  logic         jr_en,
    input  logic [31:0]  jr_addr,
    input  logic         halt,
    output logic         addr_err,
    output logic [31:0]  inst_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic [31:0]  count_q;
    logic         addr_err_q;
    logic         take;
    logic         consume;

    assign take    = (state_q == REQ) && imem.imem_valid;
    assign consume = (state_q == HOLD) && !stall;

    pc_next_calc u_pc_next (
        .pc_i      (pc_q),
        .imm26_i   (inst_q[25:0]),
        .jr_en_i   (jr_en),
        .jr_addr_i (jr_addr),
        .jump_i    (jump),
        .branch_i  (branch),
        .taken_i   (branch_taken),
        .next_pc_o (fetch_pc_d)
    );

    // state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state: halt wins over any redirect at consumption
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (imem.imem_valid) state_d = HOLD;
            HOLD:    if (!stall) state_d = halt ? HALT : REQ;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // capture returned word, advance fetch address and count on consumption
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            count_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= consume && !halt && jr_en
                          && (jr_addr[1:0] != 2'b00);
            if (take) begin
                inst_q <= imem.imem_rdata;
                pc_q   <= fetch_pc_q;
            end
            if (consume) begin
                count_q <= count_q + 32'd1;
                if (!halt) fetch_pc_q <= fetch_pc_d;
            end
        end
    end

    // state-decoded outputs
    always_comb begin
        imem.imem_req  = (state_q == REQ);
        imem.imem_addr = fetch_pc_q;
        inst_valid     = (state_q == HOLD);
    end

    assign inst_out   = inst_q;
    assign pc_out     = pc_q;
    assign addr_err   = addr_err_q;
    assign inst_count = count_q;

endmodule
